// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: register file with writeback bypass,
// immediate generation, load-use stall, and the ID/EX output register.
package core;
   typedef enum logic [2:0] {
      NOP_FORMAT,
      R_FORMAT,
      I_FORMAT,
      S_FORMAT,
      B_FORMAT,
      U_FORMAT,
      J_FORMAT
   } FORMAT_t;

   typedef logic [4:0] ALU_OP_t;
   typedef logic [4:0] MEM_OP_t;

   localparam logic [1:0] ARITHM_PRFX = 2'b01;
   localparam logic [1:0] BRANCH_PRFX = 2'b10;
   localparam logic [1:0] JUMP_PRFX   = 2'b11;

   localparam ALU_OP_t ALU_NOP   = 5'b00000;
   localparam ALU_OP_t ALU_LUI   = {JUMP_PRFX, 3'd0};
   localparam ALU_OP_t ALU_AUIPC = {JUMP_PRFX, 3'd1};
   localparam ALU_OP_t ALU_JAL   = {JUMP_PRFX, 3'd2};
   localparam ALU_OP_t ALU_JALR  = {JUMP_PRFX, 3'd3};

   localparam logic [1:0] LOAD_PRFX  = 2'b01;
   localparam logic [1:0] STORE_PRFX = 2'b10;
   localparam MEM_OP_t    MEM_NOP    = 5'b00000;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

module decode_stage
   import core::*;
#(
   parameter int XLEN           = 32,
   parameter int NREGS          = 32,
   parameter int WB_BYPASS      = 1,
   parameter int LOAD_USE_STALL = 1,
   localparam int RW            = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            wb_en_i,
   input  logic [RW-1:0]   wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            ex_ready_i,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [31:0]     ex_instr_o,
   output logic [RW-1:0]   ex_rs1_o,
   output logic [RW-1:0]   ex_rs2_o,
   output logic [RW-1:0]   ex_rd_o,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output FORMAT_t         ex_format_o,
   output ALU_OP_t         ex_alu_op_o,
   output MEM_OP_t         ex_mem_op_o,
   output logic            ex_is_branch_o,
   output logic            ex_illegal_o
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      FORMAT_t         fmt;
      ALU_OP_t         alu_op;
      MEM_OP_t         mem_op;
      logic            is_branch;
      logic            illegal;
   } id_ex_t;

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   id_ex_t          id_ex_q, id_ex_d, dec;
   logic            ex_valid_q, ex_valid_d;

   logic [6:0]    opcode;
   logic [2:0]    f3;
   logic [RW-1:0] f_rs1, f_rs2, f_rd;
   logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
   logic          ld_in_ex, stall, accept;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f_rd   = instr_i[7 +: RW];
   assign f_rs1  = instr_i[15 +: RW];
   assign f_rs2  = instr_i[20 +: RW];

   assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                   instr_i[11:7]};
   assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {instr_i[31:12], 12'b0};
   assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                   instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

   always_comb begin
      dec       = '0;
      dec.fmt   = NOP_FORMAT;
      dec.pc    = pc_i;
      dec.instr = instr_i;
      unique case (1'b1)
         opcode == OPC_OP_IMM: begin
            dec.fmt    = I_FORMAT;
            dec.rs1    = f_rs1;
            dec.rd     = f_rd;
            dec.imm    = sext(imm_i);
            dec.alu_op = {ARITHM_PRFX, f3};
            // canonical nop (addi x0,x0,0)
            if (instr_i[31:7] == '0) dec.alu_op = ALU_NOP;
         end
         opcode == OPC_OP: begin
            dec.fmt    = R_FORMAT;
            dec.rs1    = f_rs1;
            dec.rs2    = f_rs2;
            dec.rd     = f_rd;
            dec.alu_op = {ARITHM_PRFX, f3};
         end
         opcode == OPC_LOAD: begin
            dec.fmt    = I_FORMAT;
            dec.rs1    = f_rs1;
            dec.rd     = f_rd;
            dec.imm    = sext(imm_i);
            dec.mem_op = {LOAD_PRFX, f3};
         end
         opcode == OPC_STORE: begin
            dec.fmt    = S_FORMAT;
            dec.rs1    = f_rs1;
            dec.rs2    = f_rs2;
            dec.imm    = sext(imm_s);
            dec.mem_op = {STORE_PRFX, f3};
         end
         opcode == OPC_LUI: begin
            dec.fmt    = U_FORMAT;
            dec.rd     = f_rd;
            dec.imm    = sext(imm_u);
            dec.alu_op = ALU_LUI;
         end
         opcode == OPC_AUIPC: begin
            dec.fmt    = U_FORMAT;
            dec.rd     = f_rd;
            dec.imm    = sext(imm_u);
            dec.alu_op = ALU_AUIPC;
         end
         opcode == OPC_JAL: begin
            dec.fmt       = J_FORMAT;
            dec.rd        = f_rd;
            dec.imm       = sext(imm_j);
            dec.alu_op    = ALU_JAL;
            dec.is_branch = 1'b1;
         end
         opcode == OPC_JALR: begin
            dec.fmt       = I_FORMAT;
            dec.rs1       = f_rs1;
            dec.rd        = f_rd;
            dec.imm       = sext(imm_i);
            dec.alu_op    = ALU_JALR;
            dec.is_branch = 1'b1;
         end
         opcode == OPC_BRANCH: begin
            dec.fmt       = B_FORMAT;
            dec.rs1       = f_rs1;
            dec.rs2       = f_rs2;
            dec.imm       = sext(imm_b);
            dec.alu_op    = {BRANCH_PRFX, f3};
            dec.is_branch = 1'b1;
         end
         opcode == OPC_SYSTEM: begin
         end
         default: dec.illegal = 1'b1;
      endcase

      dec.rs1_data = (dec.rs1 == '0) ? '0 : rf_q[dec.rs1];
      dec.rs2_data = (dec.rs2 == '0) ? '0 : rf_q[dec.rs2];
      if (WB_BYPASS != 0 && wb_en_i) begin
         if (dec.rs1 != '0 && wb_rd_i == dec.rs1)
            dec.rs1_data = wb_data_i;
         if (dec.rs2 != '0 && wb_rd_i == dec.rs2)
            dec.rs2_data = wb_data_i;
      end
   end

   // unused source fields decode as 0, which never matches a nonzero rd
   assign ld_in_ex = ex_valid_q &&
                     (id_ex_q.mem_op[4:3] == LOAD_PRFX);
   assign stall = (LOAD_USE_STALL != 0) && ld_in_ex &&
                  (id_ex_q.rd != '0) &&
                  ((id_ex_q.rd == dec.rs1) ||
                   (id_ex_q.rd == dec.rs2));

   assign if_ready_o = rst && !stall &&
                       (!ex_valid_q || ex_ready_i);
   assign accept = if_valid_i && if_ready_o;

   always_comb begin
      ex_valid_d = ex_valid_q;
      id_ex_d    = id_ex_q;
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d = 1'b1;
         id_ex_d    = dec;
      end else if (ex_ready_i) begin
         ex_valid_d = 1'b0;
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_en_i && wb_rd_i != '0) rf_d[wb_rd_i] = wb_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_q       <= '{default: '0};
         id_ex_q    <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         id_ex_q    <= id_ex_d;
         ex_valid_q <= ex_valid_d;
      end
   end

   assign ex_valid_o     = ex_valid_q;
   assign ex_pc_o        = id_ex_q.pc;
   assign ex_instr_o     = id_ex_q.instr;
   assign ex_rs1_o       = id_ex_q.rs1;
   assign ex_rs2_o       = id_ex_q.rs2;
   assign ex_rd_o        = id_ex_q.rd;
   assign ex_rs1_data_o  = id_ex_q.rs1_data;
   assign ex_rs2_data_o  = id_ex_q.rs2_data;
   assign ex_imm_o       = id_ex_q.imm;
   assign ex_format_o    = id_ex_q.fmt;
   assign ex_alu_op_o    = id_ex_q.alu_op;
   assign ex_mem_op_o    = id_ex_q.mem_op;
   assign ex_is_branch_o = id_ex_q.is_branch;
   assign ex_illegal_o   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued
// when an instruction is offered and compared when it appears at the output.
module tb_decode_stage;
   import core::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        if_valid_i;
   logic        if_ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        wb_en_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        ex_ready_i;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_instr_o;
   logic [4:0]  ex_rs1_o;
   logic [4:0]  ex_rs2_o;
   logic [4:0]  ex_rd_o;
   logic [31:0] ex_rs1_data_o;
   logic [31:0] ex_rs2_data_o;
   logic [31:0] ex_imm_o;
   FORMAT_t     ex_format_o;
   ALU_OP_t     ex_alu_op_o;
   MEM_OP_t     ex_mem_op_o;
   logic        ex_is_branch_o;
   logic        ex_illegal_o;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
      .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o),
      .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
      .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
      .ex_imm_o(ex_imm_o), .ex_format_o(ex_format_o),
      .ex_alu_op_o(ex_alu_op_o), .ex_mem_op_o(ex_mem_op_o),
      .ex_is_branch_o(ex_is_branch_o), .ex_illegal_o(ex_illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      FORMAT_t     fmt;
      ALU_OP_t     alu;
      MEM_OP_t     mem;
      logic        br;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic exp_t observe();
      exp_t o;
      o.pc = ex_pc_o;        o.instr = ex_instr_o;
      o.rs1 = ex_rs1_o;      o.rs2 = ex_rs2_o;
      o.rd = ex_rd_o;        o.d1 = ex_rs1_data_o;
      o.d2 = ex_rs2_data_o;  o.imm = ex_imm_o;
      o.fmt = ex_format_o;   o.alu = ex_alu_op_o;
      o.mem = ex_mem_op_o;   o.br = ex_is_branch_o;
      o.ill = ex_illegal_o;
      return o;
   endfunction

   function automatic exp_t mk(
      input logic [31:0] pc, input logic [31:0] ins,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] imm,
      input FORMAT_t fmt, input ALU_OP_t alu,
      input MEM_OP_t mem, input logic br, input logic ill);
      exp_t e;
      e.pc = pc;   e.instr = ins; e.rs1 = rs1; e.rs2 = rs2;
      e.rd = rd;   e.d1 = d1;     e.d2 = d2;   e.imm = imm;
      e.fmt = fmt; e.alu = alu;   e.mem = mem; e.br = br;
      e.ill = ill;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {7'b0, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
              7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm,
      input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc);
      if_valid_i = v;
      instr_i    = ins;
      pc_i       = pc;
   endtask

   task automatic test_reset();
      exp_t z;
      z = '0;
      rst = 1'b0; flush_i = 1'b0; wb_en_i = 1'b0;
      wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
      drive(1'b1, enc_r(5'd1, 5'd2, 3'd0, 5'd3), 32'h40);
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got=%b want=0", if_ready_o);
      end
      n_cmp++;
      if (ex_valid_o !== 1'b0 || observe() !== z) begin
         n_err++;
         $display("FAIL reset_ex got valid=%b %p want all zero",
                  ex_valid_o, observe());
      end
      @(negedge clk);
      drive(1'b0, '0, '0);
      rst = 1'b1;
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         drive(1'b1, enc_r(i[4:0], i[4:0], 3'd0, 5'd0), i * 4);
         sb.push_back(mk(i * 4, instr_i, i[4:0], i[4:0], 5'd0,
                         32'h0, 32'h0, 32'h0, R_FORMAT,
                         {ARITHM_PRFX, 3'd0}, MEM_NOP, 1'b0, 1'b0));
         @(posedge clk); #1;
         n_cmp++;
         if (ex_valid_o !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL reset_rf_valid x%0d got=%b want=1",
                     i, ex_valid_o);
         end else if (observe() !== sb[0]) begin
            n_err++;
            $display("FAIL reset_rf x%0d got=%p want=%p",
                     i, observe(), sb[0]);
         end
         if (sb.size() != 0) void'(sb.pop_front());
      end
      @(negedge clk);
      drive(1'b0, '0, '0);
   endtask

   task automatic test_writeback();
      @(negedge clk);
      wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
      @(negedge clk);
      wb_en_i = 1'b0;
      drive(1'b1, enc_r(5'd5, 5'd5, 3'd0, 5'd6), 32'h100);
      sb.push_back(mk(32'h100, instr_i, 5'd5, 5'd5, 5'd6,
                      32'h1234, 32'h1234, 32'h0, R_FORMAT,
                      {ARITHM_PRFX, 3'd0}, MEM_NOP, 1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL writeback got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wb_en_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hAAAA;
      drive(1'b1, enc_i(12'hFFF, 5'd7, 3'd0, 5'd8, 7'b0010011), 32'h104);
      sb.push_back(mk(32'h104, instr_i, 5'd7, 5'd0, 5'd8,
                      32'hAAAA, 32'h0, 32'hFFFF_FFFF, I_FORMAT,
                      {ARITHM_PRFX, 3'd0}, MEM_NOP, 1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL bypass got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge clk);
      wb_en_i = 1'b0;
   endtask

   task automatic test_load_use();
      drive(1'b1, enc_i(12'h0, 5'd1, 3'd2, 5'd3, 7'b0000011), 32'h200);
      ex_ready_i = 1'b1;
      sb.push_back(mk(32'h200, instr_i, 5'd1, 5'd0, 5'd3,
                      32'h0, 32'h0, 32'h0, I_FORMAT, ALU_NOP,
                      {LOAD_PRFX, 3'd2}, 1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL load_issue got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge clk);
      drive(1'b1, enc_r(5'd2, 5'd3, 3'd0, 5'd4), 32'h204);
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL load_use_stall got=%b want=0", if_ready_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL load_use_bubble got=%b want=0", ex_valid_o);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (if_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL load_use_release got=%b want=1", if_ready_o);
      end
      sb.push_back(mk(32'h204, instr_i, 5'd3, 5'd2, 5'd4,
                      32'h0, 32'h0, 32'h0, R_FORMAT,
                      {ARITHM_PRFX, 3'd0}, MEM_NOP, 1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL load_use_add got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
   endtask

   task automatic test_backpressure_flush();
      exp_t held;
      @(negedge clk);
      drive(1'b1, {20'h12345, 5'd9, 7'b0110111}, 32'h300);
      ex_ready_i = 1'b1;
      held = mk(32'h300, instr_i, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0,
                32'h1234_5000, U_FORMAT, ALU_LUI, MEM_NOP, 1'b0, 1'b0);
      sb.push_back(held);
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL lui got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge clk);
      ex_ready_i = 1'b0;
      drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd10, 7'b0010011), 32'h304);
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp_ready got=%b want=0", if_ready_o);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (ex_valid_o !== 1'b1 || observe() !== held) begin
            n_err++;
            $display("FAIL bp_hold cyc%0d got v=%b %p want=%p",
                     c, ex_valid_o, observe(), held);
         end
      end
      @(negedge clk);
      flush_i = 1'b1;
      wb_en_i = 1'b1; wb_rd_i = 5'd11; wb_data_i = 32'h55;
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_held got=%b want=0", ex_valid_o);
      end
      @(negedge clk);
      wb_en_i = 1'b0; ex_ready_i = 1'b1;
      drive(1'b1, enc_i(12'd7, 5'd0, 3'd0, 5'd12, 7'b0010011), 32'h308);
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_drop got=%b want=0", ex_valid_o);
      end
      @(negedge clk);
      flush_i = 1'b0;
      drive(1'b1, enc_r(5'd0, 5'd11, 3'd0, 5'd0), 32'h30C);
      sb.push_back(mk(32'h30C, instr_i, 5'd11, 5'd0, 5'd0,
                      32'h55, 32'h0, 32'h0, R_FORMAT,
                      {ARITHM_PRFX, 3'd0}, MEM_NOP, 1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
         n_err++;
         $display("FAIL flush_wb got v=%b %p want=%p",
                  ex_valid_o, observe(), sb[0]);
      end
      void'(sb.pop_front());
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [7];
      exp_t        e   [7];
      ins[0] = enc_j(21'h1FFFFC, 5'd1);
      e[0] = mk(32'h400, ins[0], 5'd0, 5'd0, 5'd1, 32'h0, 32'h0,
                32'hFFFF_FFFC, J_FORMAT, ALU_JAL, MEM_NOP, 1'b1, 1'b0);
      ins[1] = enc_s(12'hFF8, 5'd7, 5'd5, 3'd2);
      e[1] = mk(32'h404, ins[1], 5'd5, 5'd7, 5'd0, 32'h1234, 32'hAAAA,
                32'hFFFF_FFF8, S_FORMAT, ALU_NOP, {STORE_PRFX, 3'd2},
                1'b0, 1'b0);
      ins[2] = enc_b(13'd16, 5'd7, 5'd5, 3'd0);
      e[2] = mk(32'h408, ins[2], 5'd5, 5'd7, 5'd0, 32'h1234, 32'hAAAA,
                32'h10, B_FORMAT, {BRANCH_PRFX, 3'd0}, MEM_NOP,
                1'b1, 1'b0);
      ins[3] = 32'h0000_007F;
      e[3] = mk(32'h40C, ins[3], 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                32'h0, NOP_FORMAT, ALU_NOP, MEM_NOP, 1'b0, 1'b1);
      ins[4] = {20'h00001, 5'd13, 7'b0010111};
      e[4] = mk(32'h410, ins[4], 5'd0, 5'd0, 5'd13, 32'h0, 32'h0,
                32'h1000, U_FORMAT, ALU_AUIPC, MEM_NOP, 1'b0, 1'b0);
      ins[5] = enc_i(12'd4, 5'd5, 3'd0, 5'd1, 7'b1100111);
      e[5] = mk(32'h414, ins[5], 5'd5, 5'd0, 5'd1, 32'h1234, 32'h0,
                32'h4, I_FORMAT, ALU_JALR, MEM_NOP, 1'b1, 1'b0);
      ins[6] = 32'h0000_0013;
      e[6] = mk(32'h418, ins[6], 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                32'h0, I_FORMAT, ALU_NOP, MEM_NOP, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         drive(1'b1, ins[k], 32'h400 + 32'(k * 4));
         sb.push_back(e[k]);
         @(posedge clk); #1;
         n_cmp++;
         if (ex_valid_o !== 1'b1 || observe() !== sb[0]) begin
            n_err++;
            $display("FAIL b2b_%0d got v=%b %p want=%p",
                     k, ex_valid_o, observe(), sb[0]);
         end
         void'(sb.pop_front());
      end
   endtask

   task automatic test_x0();
      @(negedge clk);
      wb_en_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEAD;
      drive(1'b1, enc_r(5'd0, 5'd0, 3'd0, 5'd1), 32'h500);
      sb.push_back(mk(32'h500, instr_i, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0,
                      32'h0, R_FORMAT, {ARITHM_PRFX, 3'd0}, MEM_NOP,
                      1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (observe() !== sb[0]) begin
         n_err++;
         $display("FAIL x0_bypass got=%p want=%p", observe(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge clk);
      wb_en_i = 1'b0;
      drive(1'b1, enc_r(5'd0, 5'd0, 3'd4, 5'd2), 32'h504);
      sb.push_back(mk(32'h504, instr_i, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0,
                      32'h0, R_FORMAT, {ARITHM_PRFX, 3'd4}, MEM_NOP,
                      1'b0, 1'b0));
      @(posedge clk); #1;
      n_cmp++;
      if (observe() !== sb[0]) begin
         n_err++;
         $display("FAIL x0_write got=%p want=%p", observe(), sb[0]);
      end
      void'(sb.pop_front());
      @(negedge clk);
      drive(1'b0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_writeback();
      test_bypass();
      @(negedge clk);
      test_load_use();
      test_backpressure_flush();
      test_back_to_back();
      test_x0();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
